// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand stage.
// Optional bypass logic is enabled by defining OPERAND_FORWARDING_EN.
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef logic [4:0] regaddr_t;

   localparam regaddr_t REG_ZERO = 5'd0;
   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_ctrl_t;

   // Occupancy of the single-entry pipeline register.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_t;

   // x0 is hardwired to zero, so a write to it must never be bypassed.
   function automatic logic isBypassHit(input logic we, input regaddr_t rd, input regaddr_t rs);
      return we && (rd == rs) && (rs != REG_ZERO);
   endfunction

endpackage

// File: rtl/alu_operand_stage_fwd.sv
// Per-operand bypass select: MEM result beats WB result beats register file.
// With OPERAND_FORWARDING_EN undefined the register-file data passes straight through.
module operand_fwd_mux
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  regaddr_t         rsAddr_i,
   input  logic [XLEN-1:0]  rsData_i,
   input  logic             memWe_i,
   input  regaddr_t         memRd_i,
   input  logic [XLEN-1:0]  memData_i,
   input  logic             wbWe_i,
   input  regaddr_t         wbRd_i,
   input  logic [XLEN-1:0]  wbData_i,
   output logic [XLEN-1:0]  opData_o
);

`ifdef OPERAND_FORWARDING_EN

   always_comb begin
      opData_o = rsData_i;
      if (isBypassHit(memWe_i, memRd_i, rsAddr_i)) begin
         opData_o = memData_i;
      end else if (isBypassHit(wbWe_i, wbRd_i, rsAddr_i)) begin
         opData_o = wbData_i;
      end
   end

`else

   // Bypass ports stay on the interface but carry no function in this build.
   logic unusedFwd;
   assign unusedFwd = ^{rsAddr_i, memWe_i, memRd_i, memData_i, wbWe_i, wbRd_i, wbData_i};

   assign opData_o = rsData_i;

`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Single-entry register stage between decode and ALU with operand resolution.
// Define OPERAND_FORWARDING_EN to enable MEM/WB operand bypassing.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  regaddr_t         rs1_addr,
   input  regaddr_t         rs2_addr,
   input  logic [XLEN-1:0]  imm,
   input  logic             alusrc,
   input  logic [2:0]       alu_ctrl_in,
   input  regaddr_t         rd_addr_in,
   input  logic             reg_write_in,
   input  logic             fwd_mem_we,
   input  regaddr_t         fwd_mem_rd,
   input  logic [XLEN-1:0]  fwd_mem_data,
   input  logic             fwd_wb_we,
   input  regaddr_t         fwd_wb_rd,
   input  logic [XLEN-1:0]  fwd_wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  aluop1,
   output logic [XLEN-1:0]  aluop2,
   output logic [2:0]       alu_ctrl,
   output regaddr_t         rd_addr,
   output logic             reg_write,
   output logic [15:0]      stall_cnt
);

   stage_state_t     state_q, state_d;
   logic [XLEN-1:0]  aluOp1_q, aluOp1_d;
   logic [XLEN-1:0]  aluOp2_q, aluOp2_d;
   alu_ctrl_t        aluCtrl_q, aluCtrl_d;
   regaddr_t         rdAddr_q, rdAddr_d;
   logic             regWrite_q, regWrite_d;
   logic [15:0]      stallCnt_q, stallCnt_d;

   logic [XLEN-1:0]  fwdOp1;
   logic [XLEN-1:0]  fwdOp2;
   logic [XLEN-1:0]  resolvedOp2;
   logic             stageFull;
   logic             captureEn;

   operand_fwd_mux #(
      .XLEN (XLEN)
   ) u_fwd_rs1 (
      .rsAddr_i  (rs1_addr),
      .rsData_i  (rs1_data),
      .memWe_i   (fwd_mem_we),
      .memRd_i   (fwd_mem_rd),
      .memData_i (fwd_mem_data),
      .wbWe_i    (fwd_wb_we),
      .wbRd_i    (fwd_wb_rd),
      .wbData_i  (fwd_wb_data),
      .opData_o  (fwdOp1)
   );

   operand_fwd_mux #(
      .XLEN (XLEN)
   ) u_fwd_rs2 (
      .rsAddr_i  (rs2_addr),
      .rsData_i  (rs2_data),
      .memWe_i   (fwd_mem_we),
      .memRd_i   (fwd_mem_rd),
      .memData_i (fwd_mem_data),
      .wbWe_i    (fwd_wb_we),
      .wbRd_i    (fwd_wb_rd),
      .wbData_i  (fwd_wb_data),
      .opData_o  (fwdOp2)
   );

   assign resolvedOp2 = alusrc ? imm : fwdOp2;

   assign stageFull = (state_q == ST_FULL);
   assign in_ready  = !stageFull || out_ready;
   assign captureEn = in_valid && in_ready && !flush;

   // Flush wins over a simultaneous capture; payload may keep stale values.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else if (captureEn) begin
         state_d = ST_FULL;
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_comb begin
      aluOp1_d   = aluOp1_q;
      aluOp2_d   = aluOp2_q;
      aluCtrl_d  = aluCtrl_q;
      rdAddr_d   = rdAddr_q;
      regWrite_d = regWrite_q;
      if (captureEn) begin
         aluOp1_d   = fwdOp1;
         aluOp2_d   = resolvedOp2;
         aluCtrl_d  = alu_ctrl_t'(alu_ctrl_in);
         rdAddr_d   = rd_addr_in;
         regWrite_d = reg_write_in;
      end
   end

   // Counts back-pressure cycles and sticks at the maximum.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (stageFull && !out_ready && (stallCnt_q != STALL_MAX)) begin
         stallCnt_d = stallCnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         aluOp1_q   <= '0;
         aluOp2_q   <= '0;
         aluCtrl_q  <= ALU_ADD;
         rdAddr_q   <= REG_ZERO;
         regWrite_q <= 1'b0;
         stallCnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         aluOp1_q   <= aluOp1_d;
         aluOp2_q   <= aluOp2_d;
         aluCtrl_q  <= aluCtrl_d;
         rdAddr_q   <= rdAddr_d;
         regWrite_q <= regWrite_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   assign out_valid = stageFull;
   assign aluop1    = aluOp1_q;
   assign aluop2    = aluOp2_q;
   assign alu_ctrl  = aluCtrl_q;
   assign rd_addr   = rdAddr_q;
   assign reg_write = regWrite_q && stageFull;
   assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// randomized traffic compared against a behavioural model of the stage.
module tb_alu_operand_stage;

   localparam int XLEN = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  rs1_data, rs2_data;
   logic [4:0]       rs1_addr, rs2_addr;
   logic [XLEN-1:0]  imm;
   logic             alusrc;
   logic [2:0]       alu_ctrl_in;
   logic [4:0]       rd_addr_in;
   logic             reg_write_in;
   logic             fwd_mem_we;
   logic [4:0]       fwd_mem_rd;
   logic [XLEN-1:0]  fwd_mem_data;
   logic             fwd_wb_we;
   logic [4:0]       fwd_wb_rd;
   logic [XLEN-1:0]  fwd_wb_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  aluop1, aluop2;
   logic [2:0]       alu_ctrl;
   logic [4:0]       rd_addr;
   logic             reg_write;
   logic [15:0]      stall_cnt;

   int errorCount = 0;
   int checkCount = 0;

   // Model of the stage contents: what the ALU side should currently see.
   logic             mValid;
   logic [XLEN-1:0]  mOp1, mOp2;
   logic [2:0]       mCtrl;
   logic [4:0]       mRd;
   logic             mRw;
   int               mStall;

   alu_operand_stage #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .imm          (imm),
      .alusrc       (alusrc),
      .alu_ctrl_in  (alu_ctrl_in),
      .rd_addr_in   (rd_addr_in),
      .reg_write_in (reg_write_in),
      .fwd_mem_we   (fwd_mem_we),
      .fwd_mem_rd   (fwd_mem_rd),
      .fwd_mem_data (fwd_mem_data),
      .fwd_wb_we    (fwd_wb_we),
      .fwd_wb_rd    (fwd_wb_rd),
      .fwd_wb_data  (fwd_wb_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .aluop1       (aluop1),
      .aluop2       (aluop2),
      .alu_ctrl     (alu_ctrl),
      .rd_addr      (rd_addr),
      .reg_write    (reg_write),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Operand value the architecture says the instruction should read.
   function automatic logic [XLEN-1:0] refOperand(input logic [4:0] addr, input logic [XLEN-1:0] regData);
`ifdef OPERAND_FORWARDING_EN
      if (addr != 5'd0 && fwd_mem_we && fwd_mem_rd == addr) return fwd_mem_data;
      if (addr != 5'd0 && fwd_wb_we && fwd_wb_rd == addr) return fwd_wb_data;
`endif
      return regData;
   endfunction

   task automatic modelReset();
      mValid = 1'b0;
      mOp1   = '0;
      mOp2   = '0;
      mCtrl  = 3'b000;
      mRd    = 5'd0;
      mRw    = 1'b0;
      mStall = 0;
   endtask

   // Advance the model by one rising edge using the inputs now being driven.
   task automatic modelStep();
      logic accept;
      accept = !mValid || out_ready;
      if (mValid && !out_ready && mStall < 65535) mStall++;
      if (flush) begin
         mValid = 1'b0;
      end else if (in_valid && accept) begin
         mValid = 1'b1;
         mOp1   = refOperand(rs1_addr, rs1_data);
         mOp2   = alusrc ? imm : refOperand(rs2_addr, rs2_data);
         mCtrl  = alu_ctrl_in;
         mRd    = rd_addr_in;
         mRw    = reg_write_in;
      end else if (out_ready) begin
         mValid = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] r1a, input logic [31:0] r1d,
                                input logic [4:0] r2a, input logic [31:0] r2d, input logic src,
                                input logic [31:0] immv, input logic [2:0] ctrl, input logic [4:0] rd,
                                input logic rw, input logic ordy, input logic fl);
      in_valid     = v;
      rs1_addr     = r1a;
      rs1_data     = r1d;
      rs2_addr     = r2a;
      rs2_data     = r2d;
      alusrc       = src;
      imm          = immv;
      alu_ctrl_in  = ctrl;
      rd_addr_in   = rd;
      reg_write_in = rw;
      out_ready    = ordy;
      flush        = fl;
      fwd_mem_we   = 1'b0;
      fwd_mem_rd   = 5'd0;
      fwd_mem_data = '0;
      fwd_wb_we    = 1'b0;
      fwd_wb_rd    = 5'd0;
      fwd_wb_data  = '0;
   endtask

   task automatic tick();
      modelStep();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic compareAll(input string pfx);
      checkOutput({pfx, ".out_valid"}, 32'(out_valid), 32'(mValid));
      checkOutput({pfx, ".aluop1"}, aluop1, mOp1);
      checkOutput({pfx, ".aluop2"}, aluop2, mOp2);
      checkOutput({pfx, ".alu_ctrl"}, 32'(alu_ctrl), 32'(mCtrl));
      checkOutput({pfx, ".rd_addr"}, 32'(rd_addr), 32'(mRd));
      checkOutput({pfx, ".reg_write"}, 32'(reg_write), 32'(mRw && mValid));
      checkOutput({pfx, ".stall_cnt"}, 32'(stall_cnt), 32'(mStall));
   endtask

   task automatic checkReady(input string pfx);
      #1;
      checkOutput({pfx, ".in_ready"}, 32'(in_ready), 32'(!mValid || out_ready));
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      modelReset();
      #12;
      compareAll("reset");
      checkOutput("reset.aluop1_zero", aluop1, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic capture with one-cycle latency.
      applyStimulus(1, 5'd1, 32'd5, 5'd2, 32'd7, 0, 32'h0, 3'b000, 5'd4, 1, 1, 0);
      tick();
      compareAll("basic");
      checkOutput("basic.op1_const", aluop1, 32'd5);
      checkOutput("basic.op2_const", aluop2, 32'd7);

      // MEM and WB both match rs1; MEM must win when bypass is built in.
      applyStimulus(1, 5'd3, 32'h11, 5'd9, 32'h22, 0, 32'h0, 3'b001, 5'd5, 1, 1, 0);
      fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
      fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 32'hBB;
      tick();
      compareAll("fwd_prio");
`ifdef OPERAND_FORWARDING_EN
      checkOutput("fwd_prio.op1_const", aluop1, 32'hAA);
`else
      checkOutput("fwd_prio.op1_const", aluop1, 32'h11);
`endif

      // x0 is never bypassed.
      applyStimulus(1, 5'd0, 32'd0, 5'd0, 32'd0, 1, 32'hFFFF_FFF0, 3'b010, 5'd6, 0, 1, 0);
      fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h55;
      tick();
      compareAll("x0");
      checkOutput("x0.op1_const", aluop1, 32'd0);
      checkOutput("x0.imm_select", aluop2, 32'hFFFF_FFF0);

      // Back-pressure for three cycles with a new instruction waiting.
      applyStimulus(1, 5'd7, 32'h1234, 5'd8, 32'h5678, 0, 32'h0, 3'b011, 5'd7, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkReady("stall");
         tick();
         compareAll("stall");
      end
      checkOutput("stall.count_three", 32'(stall_cnt), 32'd3);
      checkOutput("stall.held_op1", aluop1, 32'd0);
      out_ready = 1'b1;
      checkReady("release");
      tick();
      compareAll("release");
      checkOutput("release.op1_const", aluop1, 32'h1234);

      // Flush in the same cycle as a capture.
      applyStimulus(1, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 0, 32'h0, 3'b100, 5'd9, 1, 1, 1);
      tick();
      compareAll("flush");
      checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush.reg_write", 32'(reg_write), 32'd0);

      // Asynchronous reset while holding a stalled instruction.
      applyStimulus(1, 5'd2, 32'h77, 5'd3, 32'h88, 0, 32'h0, 3'b101, 5'd10, 1, 1, 0);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      compareAll("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset.out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_reset.stall_cnt", 32'(stall_cnt), 32'd0);
      checkOutput("async_reset.reg_write", 32'(reg_write), 32'd0);
      modelReset();
      @(negedge clk);
      compareAll("in_reset");
      rst_n = 1'b1;
      applyStimulus(1, 5'd4, 32'h99, 5'd5, 32'h66, 0, 32'h0, 3'b110, 5'd11, 1, 1, 0);
      tick();
      compareAll("post_reset");

      // Randomized traffic with heavy register-index overlap.
      for (int i = 0; i < 400; i++) begin
         in_valid     = ($urandom_range(0, 9) < 7);
         rs1_addr     = 5'($urandom_range(0, 3));
         rs2_addr     = 5'($urandom_range(0, 3));
         rs1_data     = $urandom;
         rs2_data     = $urandom;
         imm          = $urandom;
         alusrc       = 1'($urandom_range(0, 1));
         alu_ctrl_in  = 3'($urandom_range(0, 7));
         rd_addr_in   = 5'($urandom_range(0, 31));
         reg_write_in = 1'($urandom_range(0, 1));
         fwd_mem_we   = 1'($urandom_range(0, 1));
         fwd_mem_rd   = 5'($urandom_range(0, 3));
         fwd_mem_data = $urandom;
         fwd_wb_we    = 1'($urandom_range(0, 1));
         fwd_wb_rd    = 5'($urandom_range(0, 3));
         fwd_wb_data  = $urandom;
         out_ready    = ($urandom_range(0, 9) < 6);
         flush        = ($urandom_range(0, 9) == 0);
         checkReady("rand");
         tick();
         compareAll("rand");
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have clk  input  1  sole clock, rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  decoded instruction present; in_ready  output  1  stage can accept.
REQ-005 SHALL have rs1_data, rs2_data  input  XLEN  register-file read data; rs1_addr, rs2_addr  input  5  source indices.
REQ-006 SHALL have imm  input  XLEN  sign-extended immediate; alusrc  input  1  1 selects imm as operand 2.
REQ-007 SHALL have alu_ctrl_in  input  3  ALU opcode; rd_addr_in  input  5; reg_write_in  input  1.
REQ-008 SHALL have fwd_mem_we  input  1, fwd_mem_rd  input  5, fwd_mem_data  input  XLEN  MEM-stage bypass; fwd_wb_we, fwd_wb_rd, fwd_wb_data  same widths  WB-stage bypass.
REQ-009 SHALL have flush  input  1  discard held and incoming instruction.
REQ-010 SHALL have out_valid  output  1; out_ready  input  1  ALU side accepts.
REQ-011 SHALL have aluop1, aluop2  output  XLEN; alu_ctrl  output  3; rd_addr  output  5; reg_write  output  1  registered to ALU/writeback.
REQ-012 SHALL have stall_cnt  output  16  saturating count of back-pressure cycles.

Function
REQ-013 SHALL be a single-entry register stage: in_ready = !out_valid || out_ready (combinational).
REQ-014 SHALL capture on rising clk when in_valid && in_ready && !flush; latency 1 cycle to out_valid.
REQ-015 SHALL resolve operands before capture: op1 = fwd(rs1); op2 = alusrc ? imm : fwd(rs2).
REQ-016 fwd(rsX) SHALL select fwd_mem_data if fwd_mem_we && fwd_mem_rd==rsX && rsX!=0, else fwd_wb_data if fwd_wb_we && fwd_wb_rd==rsX && rsX!=0, else rsX_data; MEM has priority over WB.
REQ-017 Register x0 SHALL never be forwarded; source index 0 always yields rs_data.
REQ-018 While out_valid && !out_ready, all registered outputs SHALL hold stable, no capture.
REQ-019 out_valid SHALL clear next cycle when out_ready && !(in_valid) with no flush; back-to-back accept/capture in the same cycle SHALL sustain one instruction per cycle.
REQ-020 flush SHALL force out_valid=0 next cycle and override simultaneous capture; payload registers may keep stale values.
REQ-021 reg_write output SHALL be gated: reg_write = reg_write_q && out_valid.
REQ-022 stall_cnt SHALL increment each cycle out_valid && !out_ready, saturate at 16'hFFFF, never wrap.

Reset
REQ-023 rst_n low SHALL immediately set out_valid=0, aluop1=aluop2=0, alu_ctrl=3'b000 (add), rd_addr=0, reg_write=0, stall_cnt=0.
REQ-024 Reset asserted mid-handshake SHALL drop the held instruction; first capture possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro OPERAND_FORWARDING_EN SHALL, when defined, enable REQ-016 bypass logic.
REQ-026 Without OPERAND_FORWARDING_EN, fwd_* inputs SHALL be ignored and operands taken directly from rs1_data/rs2_data/imm; ports remain present.

Structure
REQ-027 Shared package alu_pkg SHALL hold XLEN default, alu_ctrl_t enum (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLL=110, SRL=111), and regaddr_t (5-bit).
REQ-028 Forwarding select SHALL be a combinational sub-module operand_fwd_mux, instantiated once per source operand.

Verification
REQ-029 Reset then in_valid, rs1_data=5, rs2_data=7, alu_ctrl_in=000, out_ready=1 -> next cycle out_valid=1, aluop1=5, aluop2=7, alu_ctrl=000.
REQ-030 rs1_addr=3, fwd_mem_we=1/rd=3/data=0xAA, fwd_wb_we=1/rd=3/data=0xBB -> aluop1=0xAA; with forwarding disabled -> aluop1=rs1_data.
REQ-031 rs1_addr=0 with fwd_mem_rd=0, fwd_mem_we=1, data=0x55, rs1_data=0 -> aluop1=0.
REQ-032 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged, stall_cnt=3; out_ready=1 -> next instruction captured.
REQ-033 flush asserted same cycle as valid capture -> out_valid=0 next cycle, reg_write=0.
REQ-034 rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 and stall_cnt=0 immediately, before next clk edge.
